// File: rtl/mul_sched.sv
// Round-robin scheduler for two requesters sharing a repeated-addition multiplier datapath.
// Optional MUL_SCHED_ZERO_BYPASS_EN: zero operands finish in a single DONE cycle, with no datapath strobes.
module mul_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] prod_out,
  output logic [7:0]  dp_data,
  output logic        ld_a,
  output logic        ld_b,
  output logic        clr_p,
  output logic        ld_p,
  output logic        dec_b,
  input  logic        eqz,
  input  logic [15:0] dp_prod
);

`ifdef MUL_SCHED_ZERO_BYPASS_EN
  localparam bit ZeroBypass = 1'b1;
`else
  localparam bit ZeroBypass = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CHECK, ADD, DONE} state_t;

  state_t     state_q;
  logic       win_q;
  logic       last_q;
  logic       win_d;
  logic [7:0] a_win_d;
  logic [7:0] b_win_d;

  // With both requesting, the requester not served last wins; last_q resets to 1 so requester 0 goes first.
  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
      win_d = ~last_q;
    end
    a_win_d = win_d ? a1 : a0;
    b_win_d = win_d ? b1 : b0;
  end

  // Every output is registered and set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      prod_out <= '0;
      dp_data  <= '0;
      ld_a     <= 1'b0;
      ld_b     <= 1'b0;
      clr_p    <= 1'b0;
      ld_p     <= 1'b0;
      dec_b    <= 1'b0;
    end else begin
      dp_data <= '0;
      ld_a    <= 1'b0;
      ld_b    <= 1'b0;
      clr_p   <= 1'b0;
      ld_p    <= 1'b0;
      dec_b   <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            win_q <= win_d;
            gnt0  <= ~win_d;
            gnt1  <= win_d;
            if (ZeroBypass && (a_win_d == '0 || b_win_d == '0)) begin
              state_q  <= DONE;
              prod_out <= '0;
              done0    <= ~win_d;
              done1    <= win_d;
            end else begin
              state_q <= LOAD_A;
              dp_data <= a_win_d;
              ld_a    <= 1'b1;
              clr_p   <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          state_q <= LOAD_B;
          dp_data <= win_q ? b1 : b0;
          ld_b    <= 1'b1;
        end
        LOAD_B: begin
          state_q <= CHECK;
        end
        CHECK: begin
          if (eqz) begin
            state_q  <= DONE;
            prod_out <= dp_prod;
            done0    <= ~win_q;
            done1    <= win_q;
          end else begin
            state_q <= ADD;
            ld_p    <= 1'b1;
            dec_b   <= 1'b1;
          end
        end
        ADD: begin
          state_q <= CHECK;
        end
        DONE: begin
          state_q <= IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          last_q  <= win_q;
        end
        default: begin
          state_q <= IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: behavioural datapath, arbitration model and product/latency predictions.
module tb_mul_sched;

`ifdef MUL_SCHED_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] prod_out;
  logic [7:0]  dp_data;
  logic        ld_a, ld_b, clr_p, ld_p, dec_b;
  logic        eqz;
  logic [15:0] dp_prod;

  always #5 clk = ~clk;

  mul_sched dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .prod_out(prod_out), .dp_data(dp_data),
    .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .ld_p(ld_p), .dec_b(dec_b),
    .eqz(eqz), .dp_prod(dp_prod)
  );

  // Repeated-addition datapath driven by the DUT strobes
  logic [7:0]  ra, rb;
  logic [15:0] rp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0; rb <= '0; rp <= '0;
    end else begin
      if (ld_a) ra <= dp_data;
      if (clr_p) rp <= '0;
      else if (ld_p) rp <= rp + {8'd0, ra};
      if (ld_b) rb <= dp_data;
      else if (dec_b) rb <= rb - 8'd1;
    end
  end
  assign eqz = (rb == 8'd0);
  assign dp_prod = rp;

  typedef struct {int who; int prod; int lat; int nadd;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int last_srv = 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t predict(input int who, input int a, input int b);
    exp_t e;
    bit byp;
    byp    = ZB && (a == 0 || b == 0);
    e.who  = who;
    e.prod = (a * b) & 16'hFFFF;
    e.lat  = byp ? 1 : 4 + 2 * b;
    e.nadd = byp ? 0 : b;
    return e;
  endfunction

  // Monitor: protocol sanity every cycle, scoreboard compare on each done pulse
  int   gcnt = 0, pcnt = 0, bad = 0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      gcnt = 0; pcnt = 0; bad = 0;
    end else begin
      if (gnt0 || gnt1) gcnt++;
      if (ld_p) pcnt++;
      if (gnt0 && gnt1) bad++;
      if (int'(ld_a) + int'(ld_b) + int'(ld_p) + int'(done0) + int'(done1) > 1) bad++;
      if (clr_p !== ld_a || dec_b !== ld_p) bad++;
      if (!(ld_a || ld_b) && dp_data != 8'd0) bad++;
      if (!(gnt0 || gnt1) && (ld_a || ld_b || ld_p || done0 || done1)) bad++;
      if ((done0 && !gnt0) || (done1 && !gnt1)) bad++;
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=done expected=none t=%0t", $time);
        end else begin
          me = exp_q.pop_front();
          check("winner", done1 ? 1 : 0, me.who);
          check("product", int'(prod_out), me.prod);
          check("latency", gcnt, me.lat);
          check("add_pulses", pcnt, me.nadd);
          check("protocol", bad, 0);
        end
        gcnt = 0; pcnt = 0; bad = 0;
      end
    end
  end

  task automatic issue(input bit r0, input bit r1, input int av0, input int bv0,
                       input int av1, input int bv1);
    int first;
    a0 = 8'(av0); b0 = 8'(bv0); a1 = 8'(av1); b1 = 8'(bv1);
    if (r0 && r1) begin
      first = (last_srv == 1) ? 0 : 1;
      exp_q.push_back(first == 0 ? predict(0, av0, bv0) : predict(1, av1, bv1));
      exp_q.push_back(first == 0 ? predict(1, av1, bv1) : predict(0, av0, bv0));
      last_srv = 1 - first;
    end else if (r0) begin
      exp_q.push_back(predict(0, av0, bv0));
      last_srv = 0;
    end else begin
      exp_q.push_back(predict(1, av1, bv1));
      last_srv = 1;
    end
    req0 = r0; req1 = r1;
  endtask

  task automatic wait_done(input bit p0_in, input bit p1_in, input bit drop0, input bit drop1);
    bit p0, p1;
    int c;
    p0 = p0_in; p1 = p1_in; c = 0;
    while ((p0 || p1) && c < 3000) begin
      @(negedge clk);
      c++;
      if (done0) begin p0 = 0; req0 = 0; end
      if (done1) begin p1 = 0; req1 = 0; end
      if (gnt0 && drop0) req0 = 0;
      if (gnt1 && drop1) req1 = 0;
    end
    if (p0 || p1) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=pending expected=done t=%0t", $time);
      req0 = 0; req1 = 0;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, int'({gnt0, gnt1, done0, done1, ld_a, ld_b, clr_p, ld_p, dec_b}), 0);
    check({name, "_prod"}, int'(prod_out), 0);
    check({name, "_data"}, int'(dp_data), 0);
  endtask

  initial begin
    int n0, c;
    bit r0, r1;
    int av0, bv0, av1, bv1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;
    @(negedge clk);

    // Both held: 0, then 1, then 0 again
    a0 = 8'd4; b0 = 8'd4; a1 = 8'd7; b1 = 8'd5;
    exp_q.push_back(predict(0, 4, 4));
    exp_q.push_back(predict(1, 7, 5));
    exp_q.push_back(predict(0, 4, 4));
    last_srv = 0;
    req0 = 1; req1 = 1; n0 = 0; c = 0;
    while ((req0 || req1) && c < 3000) begin
      @(negedge clk);
      c++;
      if (done1) req1 = 0;
      if (done0) begin n0++; if (n0 == 2) req0 = 0; end
    end
    if (req0 || req1) begin
      checks++; errors++;
      $display("FAIL rr_timeout actual=pending expected=done t=%0t", $time);
      req0 = 0; req1 = 0;
    end

    issue(1, 0, 26, 10, 0, 0);  wait_done(1, 0, 0, 0);
    issue(1, 0, 9, 0, 0, 0);    wait_done(1, 0, 0, 0);
    issue(0, 1, 0, 0, 255, 255); wait_done(0, 1, 0, 1);
    issue(0, 1, 0, 0, 0, 77);   wait_done(0, 1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin r0 = 1; r1 = 0; end
        1: begin r0 = 0; r1 = 1; end
        default: begin r0 = 1; r1 = 1; end
      endcase
      av0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      av1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      bv0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
      bv1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
      issue(r0, r1, av0, bv0, av1, bv1);
      wait_done(r0, r1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of an ADD
    a0 = 8'd50; b0 = 8'd20; req0 = 1; c = 0;
    while (!ld_p && c < 100) begin @(negedge clk); c++; end
    check("reach_add", int'(ld_p), 1);
    #2 rst = 1;
    #1 check_all_zero("async_reset");
    req0 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    last_srv = 1;
    @(negedge clk);
    issue(1, 0, 3, 2, 0, 0);
    @(negedge clk);
    check("first_grant_after_reset", int'(gnt0), 1);
    wait_done(1, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
